// File: rtl/ifetch.sv
// 6502 instruction fetch stage: reads opcode and 0-2 operand bytes at PC and
// presents one assembled instruction to execute over a valid/ready handshake.
module ifetch #(
  parameter logic [15:0] RESET_PC = 16'h8000
) (
  input  logic        clk,
  input  logic        n_reset,
  output logic        mem_req,
  output logic [15:0] mem_addr,
  input  logic [7:0]  mem_rdata,
  input  logic        mem_ack,
  output logic [7:0]  dec_ins,
  input  logic [1:0]  dec_bytes,
  output logic        ins_valid,
  input  logic        ins_ready,
  output logic [7:0]  ins_opcode,
  output logic [15:0] ins_operand,
  output logic [1:0]  ins_len,
  output logic [15:0] ins_pc,
  input  logic        jump_en,
  input  logic [15:0] jump_addr
);

  localparam logic [2:0] START    = 3'd0;
  localparam logic [2:0] FETCH_OP = 3'd1;
  localparam logic [2:0] DECODE   = 3'd2;
  localparam logic [2:0] FETCH_LO = 3'd3;
  localparam logic [2:0] FETCH_HI = 3'd4;
  localparam logic [2:0] HOLD     = 3'd5;

  logic [2:0]  state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] addr_q, addr_d;
  logic [7:0]  opcode_q, opcode_d;
  logic [15:0] operand_q, operand_d;
  logic [1:0]  len_q, len_d;
  logic [15:0] ipc_q, ipc_d;
  logic        fetching;
  logic        ack;
  logic [1:0]  dec_len;

  always_comb begin
    fetching  = (state_q == FETCH_OP) || (state_q == FETCH_LO) || (state_q == FETCH_HI);
    ack       = fetching && mem_ack;
    dec_len   = (dec_bytes == 2'd0) ? 2'd1 : dec_bytes;
    state_d   = state_q;
    pc_d      = pc_q;
    addr_d    = fetching ? pc_q : addr_q;
    opcode_d  = opcode_q;
    operand_d = operand_q;
    len_d     = len_q;
    ipc_d     = ipc_q;

    // Redirect wins over everything; a same-cycle ack is simply not consumed.
    if (jump_en) begin
      pc_d    = jump_addr;
      state_d = FETCH_OP;
    end else begin
      case (state_q)
        START: state_d = FETCH_OP;
        FETCH_OP: if (ack) begin
          opcode_d  = mem_rdata;
          ipc_d     = pc_q;
          operand_d = '0;
          pc_d      = pc_q + 16'd1;
          state_d   = DECODE;
        end
        DECODE: begin
          len_d   = dec_len;
          state_d = (dec_len == 2'd1) ? HOLD : FETCH_LO;
        end
        FETCH_LO: if (ack) begin
          operand_d[7:0] = mem_rdata;
          pc_d           = pc_q + 16'd1;
          state_d        = (len_q == 2'd2) ? HOLD : FETCH_HI;
        end
        FETCH_HI: if (ack) begin
          operand_d[15:8] = mem_rdata;
          pc_d            = pc_q + 16'd1;
          state_d         = HOLD;
        end
        HOLD: if (ins_ready) state_d = FETCH_OP;
        default: state_d = START;
      endcase
    end
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q   <= START;
      pc_q      <= RESET_PC;
      addr_q    <= '0;
      opcode_q  <= '0;
      operand_q <= '0;
      len_q     <= '0;
      ipc_q     <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      addr_q    <= addr_d;
      opcode_q  <= opcode_d;
      operand_q <= operand_d;
      len_q     <= len_d;
      ipc_q     <= ipc_d;
    end
  end

  // Outside the fetch states the address bus keeps the last address presented.
  assign mem_req     = fetching;
  assign mem_addr    = fetching ? pc_q : addr_q;
  assign dec_ins     = opcode_q;
  assign ins_valid   = (state_q == HOLD);
  assign ins_opcode  = opcode_q;
  assign ins_operand = operand_q;
  assign ins_len     = len_q;
  assign ins_pc      = ipc_q;

endmodule

// File: tb/tb_ifetch.sv
// Directed vector bench for ifetch: byte-addressed memory responder with
// configurable wait states, a small opcode-length decoder, and handshake checks.
module tb_ifetch;

  logic        clk = 1'b0;
  logic        n_reset;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic [7:0]  mem_rdata;
  logic        mem_ack;
  logic [7:0]  dec_ins;
  logic [1:0]  dec_bytes;
  logic        ins_valid;
  logic        ins_ready;
  logic [7:0]  ins_opcode;
  logic [15:0] ins_operand;
  logic [1:0]  ins_len;
  logic [15:0] ins_pc;
  logic        jump_en;
  logic [15:0] jump_addr;

  ifetch #(.RESET_PC(16'h8000)) dut (
    .clk(clk), .n_reset(n_reset),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .dec_ins(dec_ins), .dec_bytes(dec_bytes),
    .ins_valid(ins_valid), .ins_ready(ins_ready), .ins_opcode(ins_opcode),
    .ins_operand(ins_operand), .ins_len(ins_len), .ins_pc(ins_pc),
    .jump_en(jump_en), .jump_addr(jump_addr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] addr;
    logic [7:0]  b0, b1, b2;
    bit          jump;
    int unsigned wait_cyc;
    int unsigned hold_cyc;
    bit          stray;
    logic [7:0]  e_op;
    logic [15:0] e_operand;
    logic [1:0]  e_len;
    logic [15:0] e_next;
  } vec_t;

  vec_t        vecs [7];
  logic [7:0]  mem [0:65535];
  logic [15:0] reads [$];
  int          tests = 0;
  int          fails = 0;
  int unsigned wait_cfg = 0;
  int unsigned wcnt = 0;
  bit          stray = 1'b0;
  bit          pend = 1'b0;
  bit          ack_real = 1'b0;
  logic [15:0] pend_addr = '0;
  logic [15:0] ack_addr = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [1:0] dec_model(input logic [7:0] op);
    case (op)
      8'hA9:   return 2'd2;
      8'h4C:   return 2'd3;
      8'h00:   return 2'd0;
      default: return 2'd1;
    endcase
  endfunction

  // One clock: log consumed reads at the edge, then drive memory/decoder at negedge.
  task automatic cyc();
    logic jumped;
    @(posedge clk);
    jumped = jump_en;
    if (mem_ack && ack_real && !jumped && n_reset) reads.push_back(ack_addr);
    if (jumped) pend = 1'b0;
    @(negedge clk);
    dec_bytes = dec_model(dec_ins);
    if (mem_req) begin
      if (pend) chk("addr_stable", 64'({mem_req, mem_addr}), 64'({1'b1, pend_addr}));
      ack_real = 1'b1;
      if (wcnt >= wait_cfg) begin
        mem_ack = 1'b1; mem_rdata = mem[mem_addr]; ack_addr = mem_addr;
        wcnt = 0; pend = 1'b0;
      end else begin
        mem_ack = 1'b0; mem_rdata = 8'($urandom);
        wcnt++; pend = 1'b1; pend_addr = mem_addr;
      end
    end else begin
      ack_real = 1'b0; wcnt = 0; pend = 1'b0;
      mem_ack = stray; mem_rdata = 8'($urandom);
    end
  endtask

  task automatic wait_valid(output int unsigned n);
    n = 0;
    while (!ins_valid && n < 40) begin
      cyc();
      n++;
    end
    chk("valid_timeout", 64'(ins_valid), 64'd1);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_req_valid"}, 64'({mem_req, ins_valid}), 64'd0);
    chk({tag, "_addr"}, 64'(mem_addr), 64'd0);
    chk({tag, "_ins"}, 64'({dec_ins, ins_opcode, ins_operand, ins_len, ins_pc}), 64'd0);
  endtask

  task automatic run_vec(input vec_t v);
    logic [15:0] a;
    logic [15:0] last;
    int unsigned n;
    a = v.addr; mem[a] = v.b0;
    a = a + 16'd1; mem[a] = v.b1;
    a = a + 16'd1; mem[a] = v.b2;
    last = v.addr + 16'(v.e_len) - 16'd1;
    wait_cfg = v.wait_cyc;
    stray = v.stray;
    reads.delete();
    if (v.jump) begin
      jump_en = 1'b1; jump_addr = v.addr;
      cyc();
      jump_en = 1'b0;
    end
    wait_valid(n);
    if (v.jump && v.wait_cyc == 0) chk("latency", 64'(n), 64'(v.e_len) + 64'd1);
    chk("opcode", 64'(ins_opcode), 64'(v.e_op));
    chk("dec_ins", 64'(dec_ins), 64'(v.e_op));
    chk("operand", 64'(ins_operand), 64'(v.e_operand));
    chk("len", 64'(ins_len), 64'(v.e_len));
    chk("ins_pc", 64'(ins_pc), 64'(v.addr));
    chk("n_reads", 64'(reads.size()), 64'(v.e_len));
    if (reads.size() > 0) begin
      chk("first_read", 64'(reads[0]), 64'(v.addr));
      chk("last_read", 64'(reads[reads.size() - 1]), 64'(last));
    end
    for (int unsigned h = 0; h < v.hold_cyc; h++) begin
      cyc();
      chk("hold_valid_req", 64'({ins_valid, mem_req}), 64'b10);
      chk("hold_out", 64'({ins_opcode, ins_operand, ins_len, ins_pc}),
          64'({v.e_op, v.e_operand, v.e_len, v.addr}));
    end
    ins_ready = 1'b1;
    cyc();
    ins_ready = 1'b0;
    stray = 1'b0;
    chk("after_hs_valid", 64'(ins_valid), 64'd0);
    chk("next_fetch", 64'({mem_req, mem_addr}), 64'({1'b1, v.e_next}));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int unsigned n;
    vecs[0] = '{16'h8000, 8'hA9, 8'h42, 8'h00, 1'b0, 0, 0, 1'b0, 8'hA9, 16'h0042, 2'd2, 16'h8002};
    vecs[1] = '{16'h9000, 8'h4C, 8'h34, 8'h12, 1'b1, 0, 0, 1'b0, 8'h4C, 16'h1234, 2'd3, 16'h9003};
    vecs[2] = '{16'h8000, 8'hEA, 8'h00, 8'h00, 1'b1, 0, 5, 1'b1, 8'hEA, 16'h0000, 2'd1, 16'h8001};
    vecs[3] = '{16'h8000, 8'hA9, 8'h42, 8'h00, 1'b1, 3, 0, 1'b0, 8'hA9, 16'h0042, 2'd2, 16'h8002};
    vecs[4] = '{16'hFFFF, 8'hA9, 8'h42, 8'h00, 1'b1, 0, 0, 1'b0, 8'hA9, 16'h0042, 2'd2, 16'h0001};
    vecs[5] = '{16'h7000, 8'h00, 8'hFF, 8'hFF, 1'b1, 0, 2, 1'b1, 8'h00, 16'h0000, 2'd1, 16'h7001};
    vecs[6] = '{16'hFFFE, 8'h4C, 8'h34, 8'h12, 1'b1, 1, 0, 1'b0, 8'h4C, 16'h1234, 2'd3, 16'h0001};

    n_reset = 1'b0; mem_ack = 1'b0; mem_rdata = '0; dec_bytes = '0;
    ins_ready = 1'b0; jump_en = 1'b0; jump_addr = '0;
    repeat (2) @(negedge clk);
    check_zero("reset");

    // Fetch straight out of reset, then the directed vectors.
    n_reset = 1'b1;
    for (int i = 0; i < 7; i++) run_vec(vecs[i]);

    // Redirect while the low operand byte is being acknowledged.
    wait_cfg = 0; stray = 1'b0;
    mem[16'h8800] = 8'h4C; mem[16'h8801] = 8'h11; mem[16'h8802] = 8'h22;
    mem[16'hC000] = 8'hEA;
    reads.delete();
    jump_en = 1'b1; jump_addr = 16'h8800;
    cyc();
    jump_en = 1'b0;
    cyc();
    cyc();
    chk("t5_in_fetch_lo", 64'({mem_req, mem_ack, mem_addr}), 64'({2'b11, 16'h8801}));
    jump_en = 1'b1; jump_addr = 16'hC000;
    cyc();
    jump_en = 1'b0;
    chk("t5_redirect", 64'({ins_valid, mem_req, mem_addr}), 64'({2'b01, 16'hC000}));
    wait_valid(n);
    chk("t5_ins", 64'({ins_opcode, ins_operand, ins_len, ins_pc}),
        64'({8'hEA, 16'h0000, 2'd1, 16'hC000}));
    chk("t5_reads", 64'(reads.size()), 64'd2);
    ins_ready = 1'b1;
    cyc();
    ins_ready = 1'b0;

    // Wrap-around fetch, then asynchronous reset while holding the instruction.
    mem[16'hFFFF] = 8'hA9; mem[16'h0000] = 8'h42;
    jump_en = 1'b1; jump_addr = 16'hFFFF;
    cyc();
    jump_en = 1'b0;
    wait_valid(n);
    chk("t6_ins", 64'({ins_opcode, ins_operand, ins_len, ins_pc}),
        64'({8'hA9, 16'h0042, 2'd2, 16'hFFFF}));
    n_reset = 1'b0;
    #1;
    check_zero("hold_reset");
    mem_ack = 1'b0;
    cyc();
    check_zero("hold_reset_cyc");

    // Redirect issued in the very first cycle after reset (START state).
    n_reset = 1'b1;
    run_vec('{16'hA000, 8'hEA, 8'h00, 8'h00, 1'b1, 0, 0, 1'b0, 8'hEA, 16'h0000, 2'd1, 16'hA001});

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
